// File: rtl/fp_divider_seq.sv
// rtl/fp_divider_seq.sv - iterative single-precision divider, one quotient bit per clock (optional FP_DIV_EXCEPT_EN)
module fp_divider_seq #(
   parameter int MANT_W = 23,
   parameter int EXP_W  = 8,
   parameter int BIAS   = 127
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [EXP_W+MANT_W:0]     A,
   input  logic [EXP_W+MANT_W:0]     B,
   output logic                      busy,
   output logic                      done,
   output logic [EXP_W+MANT_W:0]     Quotient,
   output logic [1:0]                flags
);

   localparam int MW = MANT_W + 1;   // mantissa with hidden bit
   localparam int RW = MANT_W + 2;   // partial remainder
   localparam int QW = MANT_W + 3;   // quotient bits: 1 integer, MANT_W fraction, guard, round
   localparam int EW = EXP_W + 2;    // signed exponent working width

   localparam logic signed [EW-1:0] EBIAS = EW'(BIAS);
   localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
   localparam logic [4:0]           LAST_ITER = 5'(QW - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      NORM = 2'd2
   } state_t;

   state_t state, nextState;

   logic              sign;
   logic [EXP_W-1:0]  expA, expB;
   logic [MW-1:0]     mB;
   logic              zA, zB;
   logic [RW-1:0]     rem;
   logic [QW-1:0]     q;
   logic [4:0]        iter;

   logic              qbit;
   logic [MW-1:0]     diffLow;
   logic [RW-1:0]     remNext;

   logic signed [EW-1:0] expDiff, eBase, eRnd;
   logic [MANT_W-1:0]    fracRaw, frac;
   logic [MANT_W:0]      fracSum;
   logic                 rnd;
   logic [EXP_W+MANT_W:0] resultComb;
   logic [1:0]           flagsComb;

   // State register; reset abandons any operation in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   // Next-state: start only honoured while idle, fixed 26 divide steps then one normalise step
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (start) nextState = DIV;
         DIV:     if (iter == LAST_ITER) nextState = NORM;
         NORM:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // One restoring-division step: subtract divisor when it fits, then shift remainder left
   always_comb begin
      qbit    = (rem >= {1'b0, mB});
      diffLow = rem[RW-2:0] - mB;   // fits because rem < 2*mB throughout
      remNext = qbit ? {diffLow, 1'b0} : {rem[RW-2:0], 1'b0};
   end

   // Normalise, round half-up, and select the special-case or exceptional result
   always_comb begin
      expDiff = $signed({2'b00, expA}) - $signed({2'b00, expB}) + EBIAS;
      if (q[QW-1]) begin
         fracRaw = q[QW-2:2];
         rnd     = q[1];
         eBase   = expDiff;
      end else begin
         fracRaw = q[QW-3:1];
         rnd     = q[0];
         eBase   = expDiff - EW'(1);
      end
      fracSum = {1'b0, fracRaw} + {{MANT_W{1'b0}}, rnd};
      if (fracSum[MANT_W]) begin
         frac = '0;
         eRnd = eBase + EW'(1);
      end else begin
         frac = fracSum[MANT_W-1:0];
         eRnd = eBase;
      end

      flagsComb  = 2'b00;
      resultComb = {sign, eRnd[EXP_W-1:0], frac};
      if (zA) begin
         resultComb = '0;
      end else if (zB) begin
         resultComb = {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      end
`ifdef FP_DIV_EXCEPT_EN
      else if (eRnd >= EMAX) begin
         resultComb = {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
         flagsComb  = 2'b10;
      end else if (eRnd <= $signed(EW'(0))) begin
         resultComb = {sign, {(EXP_W+MANT_W){1'b0}}};
         flagsComb  = 2'b01;
      end
`endif
   end

   // Operand capture, divide iteration, result register and handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sign     <= 1'b0;
         expA     <= '0;
         expB     <= '0;
         mB       <= '0;
         zA       <= 1'b0;
         zB       <= 1'b0;
         rem      <= '0;
         q        <= '0;
         iter     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         Quotient <= '0;
         flags    <= 2'b00;
      end else begin
         busy <= (nextState != IDLE);
         done <= (state == NORM);
         case (state)
            IDLE: begin
               if (start) begin
                  sign <= A[EXP_W+MANT_W] ^ B[EXP_W+MANT_W];
                  expA <= A[EXP_W+MANT_W-1:MANT_W];
                  expB <= B[EXP_W+MANT_W-1:MANT_W];
                  mB   <= {1'b1, B[MANT_W-1:0]};
                  zA   <= (A[EXP_W+MANT_W-1:0] == '0);
                  zB   <= (B[EXP_W+MANT_W-1:0] == '0);
                  rem  <= {2'b01, A[MANT_W-1:0]};
                  q    <= '0;
                  iter <= '0;
               end
            end
            DIV: begin
               rem  <= remNext;
               q    <= {q[QW-2:0], qbit};
               iter <= iter + 5'd1;
            end
            NORM: begin
               Quotient <= resultComb;
               flags    <= flagsComb;
            end
            default: ;
         endcase
      end
   end

endmodule
